// File: rtl/if2_pkg.sv
// Shared definitions for the IF2 predecoder: opcodes, branch classes and
// offset helpers used by both the decoder and the bench-facing outputs.
package if2_pkg;

  localparam logic [5:0] OP_JIRL    = 6'h13;
  localparam logic [5:0] OP_B       = 6'h14;
  localparam logic [5:0] OP_BL      = 6'h15;
  localparam logic [5:0] OP_COND_LO = 6'h16;
  localparam logic [5:0] OP_COND_HI = 6'h1b;

  localparam int OFFS16_W = 16;
  localparam int OFFS26_W = 26;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JUMP = 2'b10,
    BR_JIRL = 2'b11
  } br_type_e;

  function automatic br_type_e classify(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    if (op >= OP_COND_LO && op <= OP_COND_HI) return BR_COND;
    if (op == OP_B || op == OP_BL)            return BR_JUMP;
    if (op == OP_JIRL)                        return BR_JIRL;
    return BR_NONE;
  endfunction

  function automatic logic [31:0] offs16(input logic [31:0] ir);
    return {{(30 - OFFS16_W){ir[25]}}, ir[25:10], 2'b00};
  endfunction

  function automatic logic [31:0] offs26(input logic [31:0] ir);
    return {{(30 - OFFS26_W){ir[9]}}, ir[9:0], ir[25:10], 2'b00};
  endfunction

  // Canonical return: jirl r0, r1, 0.
  function automatic logic is_return(input logic [31:0] ir);
    return (ir[4:0] == 5'd0) && (ir[9:5] == 5'd1) && (ir[25:10] == 16'd0);
  endfunction

endpackage

// File: rtl/if2_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module if2_ras #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty,
  output logic        full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]    mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;

  assign top   = mem[ptr - 1'b1];
  assign empty = (count == '0);
  assign full  = (count == (PTR_W + 1)'(DEPTH));

  // NOTE: storage is not reset; count gating makes stale entries unobservable
  // and leaving the array out of reset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/if2_predecoder_ras.sv
// IF2 stage: predecodes a fetch packet, predicts the first taken transfer
// (BTFN, direct jumps, RAS returns) and registers the result in one stage.
module if2_predecoder_ras
  import if2_pkg::*;
#(
  parameter  int FETCH_W   = 2,
  parameter  int RAS_DEPTH = 8,
  localparam int SLOT_W    = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [32*FETCH_W-1:0]  in_ir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [32*FETCH_W-1:0]  out_ir,
  output logic [FETCH_W-1:0]     out_slot_mask,
  output logic [2*FETCH_W-1:0]   out_br_type,
  output logic                   out_redirect,
  output logic [31:0]            out_redirect_pc,
  output logic [SLOT_W-1:0]      out_redirect_slot
);

  logic                  found;
  logic [SLOT_W-1:0]     sel_slot;
  logic [31:0]           sel_target;
  logic [31:0]           sel_pc;
  logic                  sel_is_bl;
  logic                  sel_is_ret;
  logic [FETCH_W-1:0]    mask;
  logic [2*FETCH_W-1:0]  br_vec;

  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic        ras_full;
  logic        accept;

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // NOTE: every variable gets a default before the loop so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    found      = 1'b0;
    sel_slot   = '0;
    sel_target = '0;
    sel_pc     = '0;
    sel_is_bl  = 1'b0;
    sel_is_ret = 1'b0;
    br_vec     = '0;
    mask       = '1;
    for (int k = 0; k < FETCH_W; k++) begin
      logic [31:0] ir_k;
      logic [31:0] pc_k;
      br_type_e    bt;
      logic        taken;
      logic [31:0] target;
      ir_k   = in_ir[32*k +: 32];
      pc_k   = in_pc + 32'(4 * k);
      bt     = classify(ir_k);
      taken  = 1'b0;
      target = '0;
      br_vec[2*k +: 2] = bt;
      case (bt)
        BR_COND: begin
          taken  = offs16(ir_k)[31];
          target = pc_k + offs16(ir_k);
        end
        BR_JUMP: begin
          taken  = 1'b1;
          target = pc_k + offs26(ir_k);
        end
        BR_JIRL: begin
          taken  = is_return(ir_k);
          target = ras_empty ? pc_k + 32'd4 : ras_top;
        end
        default: ;
      endcase
      if (taken && !found) begin
        found      = 1'b1;
        sel_slot   = SLOT_W'(k);
        sel_target = target;
        sel_pc     = pc_k;
        sel_is_bl  = (ir_k[31:26] == OP_BL);
        sel_is_ret = (bt == BR_JIRL);
      end
    end
    for (int k = 0; k < FETCH_W; k++) begin
      mask[k] = !found || (SLOT_W'(k) <= sel_slot);
    end
  end

  // Only the winning slot touches the stack, so at most one op per cycle.
  assign ras_push = accept && found && sel_is_bl;
  assign ras_pop  = accept && found && sel_is_ret && !ras_empty;

  if2_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (sel_pc + 32'd4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_pc            <= '0;
      out_ir            <= '0;
      out_slot_mask     <= '0;
      out_br_type       <= '0;
      out_redirect      <= 1'b0;
      out_redirect_pc   <= '0;
      out_redirect_slot <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_pc            <= in_pc;
        out_ir            <= in_ir;
        out_slot_mask     <= mask;
        out_br_type       <= br_vec;
        out_redirect      <= found;
        out_redirect_pc   <= sel_target;
        out_redirect_slot <= sel_slot;
      end
    end
  end

endmodule

// File: tb/tb_if2_predecoder_ras.sv
// Scoreboard bench for if2_predecoder_ras (FETCH_W=2, RAS_DEPTH=8).
module tb_if2_predecoder_ras;

  localparam logic [31:0] ADD = 32'h0010_4C21;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] ir;
    logic [1:0]  mask;
    logic [3:0]  br;
    logic        redir;
    logic [31:0] rpc;
    logic        slot;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [63:0] in_ir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [63:0] out_ir;
  logic [1:0]  out_slot_mask;
  logic [3:0]  out_br_type;
  logic        out_redirect;
  logic [31:0] out_redirect_pc;
  logic        out_redirect_slot;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  if2_predecoder_ras #(.FETCH_W(2), .RAS_DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pc             (in_pc),
    .in_ir             (in_ir),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_ir            (out_ir),
    .out_slot_mask     (out_slot_mask),
    .out_br_type       (out_br_type),
    .out_redirect      (out_redirect),
    .out_redirect_pc   (out_redirect_pc),
    .out_redirect_slot (out_redirect_slot)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_jump(input logic [5:0] op, input int offs);
    logic [25:0] o;
    o = 26'(offs >>> 2);
    return {op, o[15:0], o[25:16]};
  endfunction

  function automatic logic [31:0] enc_beq(input int offs);
    logic [15:0] o;
    o = 16'(offs >>> 2);
    return {6'h16, o, 5'd2, 5'd1};
  endfunction

  localparam logic [31:0] RET      = {6'h13, 16'h0, 5'd1, 5'd0};
  localparam logic [31:0] JIRL_CALL = {6'h13, 16'h0, 5'd1, 5'd1};

  // Drive one packet, wait for acceptance, optionally record the expectation.
  task automatic send(input logic [31:0] pc, input logic [31:0] s0, input logic [31:0] s1,
                      input logic [1:0] mask, input logic [3:0] br, input logic redir,
                      input logic [31:0] rpc, input logic slot, input bit track);
    exp_t e;
    bit   ok;
    in_valid = 1'b1;
    in_pc    = pc;
    in_ir    = {s1, s0};
    ok       = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) check("send_timeout", 0, 1);
    if (ok && track) begin
      e.pc = pc; e.ir = {s1, s0}; e.mask = mask; e.br = br;
      e.redir = redir; e.rpc = rpc; e.slot = slot;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {32'd0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_pc",          {32'd0, out_pc},          {32'd0, e.pc});
        check("out_ir",          out_ir,                   e.ir);
        check("out_slot_mask",   {62'd0, out_slot_mask},   {62'd0, e.mask});
        check("out_br_type",     {60'd0, out_br_type},     {60'd0, e.br});
        check("out_redirect",    {63'd0, out_redirect},    {63'd0, e.redir});
        check("out_redirect_pc", {32'd0, out_redirect_pc}, {32'd0, e.rpc});
        if (e.redir) check("out_redirect_slot", {63'd0, out_redirect_slot}, {63'd0, e.slot});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_ir = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  {63'd0, out_valid}, 0);
    check("rst_out_pc",     {32'd0, out_pc}, 0);
    check("rst_out_ir",     out_ir, 0);
    check("rst_mask_br",    {58'd0, out_slot_mask, out_br_type}, 0);
    check("rst_redirect",   {32'd0, out_redirect_pc}, 0);
    check("rst_redir_bits", {62'd0, out_redirect, out_redirect_slot}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // add + bl +0x100: call from slot 1, pushes 0x1C000008
    send(32'h1C00_0000, ADD, enc_jump(6'h15, 32'h100), 2'b11, 4'b1000, 1, 32'h1C00_0104, 1, 1);
    // return at slot 0 pops it
    send(32'h1C00_0104, RET, ADD, 2'b01, 4'b0011, 1, 32'h1C00_0008, 0, 1);
    // stack now empty: return falls back to pc+4
    send(32'h1C00_0200, RET, ADD, 2'b01, 4'b0011, 1, 32'h1C00_0204, 0, 1);
    // backward beq taken, forward beq not taken
    send(32'h1C00_0010, enc_beq(-4), ADD, 2'b01, 4'b0001, 1, 32'h1C00_000C, 0, 1);
    send(32'h1C00_0010, enc_beq(8),  ADD, 2'b11, 4'b0001, 0, 32'h0, 0, 1);
    // non-return jirl is not taken; b -0x1000 in slot 1 wins
    send(32'h1C00_1000, JIRL_CALL, enc_jump(6'h14, -32'h1000), 2'b11, 4'b1011, 1, 32'h1C00_0004, 1, 1);
    // b in slot 0 shadows bl in slot 1: no push
    send(32'h1C00_2000, enc_jump(6'h14, 32'h20), enc_jump(6'h15, 32'h40), 2'b01, 4'b1010, 1,
         32'h1C00_2020, 0, 1);
    send(32'h1C00_3000, RET, ADD, 2'b01, 4'b0011, 1, 32'h1C00_3004, 0, 1);

    // Nine calls overflow an 8-deep stack, then nine returns.
    for (int i = 0; i < 9; i++) begin
      logic [31:0] pc;
      pc = 32'h1C01_0000 + 32'(i * 32'h100);
      send(pc, enc_jump(6'h15, 32'h40), ADD, 2'b01, 4'b0010, 1, pc + 32'h40, 0, 1);
    end
    for (int j = 0; j < 9; j++) begin
      logic [31:0] pc;
      logic [31:0] rpc;
      pc  = 32'h1C02_0000 + 32'(j * 32'h10);
      rpc = (j < 8) ? 32'h1C01_0000 + 32'((8 - j) * 32'h100) + 32'd4 : pc + 32'd4;
      send(pc, RET, ADD, 2'b01, 4'b0011, 1, rpc, 0, 1);
    end

    // Stall: hold a call packet, then flush it; its push must survive.
    send(32'h1C03_0000, enc_jump(6'h15, 32'h80), ADD, 2'b01, 4'b0010, 1, 32'h1C03_0080, 0, 0);
    out_ready = 1'b0;
    in_pc     = 32'h1C04_0000;
    in_ir     = {ADD, RET};
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready",  {63'd0, in_ready}, 0);
      check("stall_out_valid", {63'd0, out_valid}, 1);
      check("stall_out_pc",    {32'd0, out_pc}, {32'd0, 32'h1C03_0000});
      check("stall_rpc",       {32'd0, out_redirect_pc}, {32'd0, 32'h1C03_0080});
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {63'd0, out_valid}, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h1C04_0000, RET, ADD, 2'b01, 4'b0011, 1, 32'h1C03_0004, 0, 1);

    // Reset mid-stream discards stack contents.
    send(32'h1C05_0000, enc_jump(6'h15, 32'h80), ADD, 2'b01, 4'b0010, 1, 32'h1C05_0080, 0, 1);
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'h1C06_0000, RET, ADD, 2'b01, 4'b0011, 1, 32'h1C06_0004, 0, 1);
    idle();

    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check("drain", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if2_predecoder_ras.md
IF2_PREDECODER_RAS -- requirements
Module: if2_predecoder_ras

Interface
REQ-001 SHALL have parameter FETCH_W, default 2, instructions per fetch packet (legal 1..4).
REQ-002 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries (power of 2, >=2).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  discard the held output packet.
REQ-006 SHALL have port in_valid  in  1  upstream packet valid.
REQ-007 SHALL have port in_ready  out  1  packet accepted when in_valid&in_ready.
REQ-008 SHALL have port in_pc  in  32  PC of slot 0, word aligned.
REQ-009 SHALL have port in_ir  in  32*FETCH_W  slot k at bits [32k+31:32k].
REQ-010 SHALL have port out_valid  out  1  output packet valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts when out_valid&out_ready.
REQ-012 SHALL have port out_pc  out  32  registered in_pc.
REQ-013 SHALL have port out_ir  out  32*FETCH_W  registered in_ir.
REQ-014 SHALL have port out_slot_mask  out  FETCH_W  bit k set = slot k is on the predicted path.
REQ-015 SHALL have port out_br_type  out  2*FETCH_W  per slot: 00 other, 01 beq/bne/blt/bge/bltu/bgeu, 10 b/bl, 11 jirl.
REQ-016 SHALL have port out_redirect  out  1  packet predicts a taken control transfer.
REQ-017 SHALL have port out_redirect_pc  out  32  predicted target; 0 when out_redirect=0.
REQ-018 SHALL have port out_redirect_slot  out  max(1,$clog2(FETCH_W))  slot index of redirect.

Function
REQ-019 SHALL decode slot k at pc_k = in_pc + 4k by opcode ir[31:26]: 0x16-0x1b cond, 0x14 b, 0x15 bl, 0x13 jirl.
REQ-020 SHALL form offsets: cond/jirl sign-extend {ir[25:10],2'b00} to 32 bits; b/bl sign-extend {ir[9:0],ir[25:10],2'b00}; target = pc_k + offset, modulo 2^32.
REQ-021 SHALL predict: cond taken iff offset negative (BTFN); b, bl always taken; jirl taken only when return form (rd=0, rj=1, offs16=0), target = RAS top; other jirl not taken.
REQ-022 SHALL select redirect slot = lowest k predicted taken; out_slot_mask bits above it cleared; no taken slot -> mask all ones, out_redirect=0.
REQ-023 SHALL act on RAS only for the redirect slot, only on input handshake: bl pushes pc_k+4; return jirl pops; at most one RAS op per cycle.
REQ-024 SHALL, on push when full, overwrite oldest entry (pointer wrap), count saturating at RAS_DEPTH.
REQ-025 SHALL, on return with RAS empty, predict target pc_k+4, redirect=1, no pop, count stays 0.
REQ-026 SHALL register results in one output stage: latency 1 cycle from accepted input to out_valid.
REQ-027 SHALL drive in_ready = !out_valid | out_ready (combinational, no bubble under continuous streaming).
REQ-028 SHALL hold all out_* stable while out_valid & !out_ready.
REQ-029 SHALL, on flush, clear out_valid next cycle and ignore a same-cycle input (in_ready=0 while flush); RAS is not rolled back.

Reset
REQ-030 SHALL, on rst, clear out_valid, out_redirect, out_slot_mask, out_br_type, out_redirect_pc, out_redirect_slot, out_pc, out_ir to 0 and RAS count/pointer to 0.
REQ-031 SHALL give rst priority over flush and handshakes; rst mid-stream discards held packet and RAS contents.

Structure
REQ-032 SHALL place opcode constants, br_type enum (BR_NONE/BR_COND/BR_JUMP/BR_JIRL) and offset widths in shared package if2_pkg.
REQ-033 SHALL implement the stack as sub-module if2_ras (push, pop, push_data, top, empty, full).

Verification
REQ-034 SHALL test: FETCH_W=2, in_pc=0x1C000000, slot0 add, slot1 bl offs=+0x100 -> next cycle redirect=1, slot=1, pc=0x1C000104, mask=11, RAS top=0x1C000008.
REQ-035 SHALL test: after REQ-034, packet slot0 return jirl at 0x1C000104 -> redirect_pc=0x1C000008, mask=01, RAS empty.
REQ-036 SHALL test: slot0 beq offs=-4 at 0x1C000010 -> redirect_pc=0x1C00000C, mask=01; same with offs=+8 -> redirect=0, mask=11.
REQ-037 SHALL test: RAS_DEPTH=8, nine bl pushes then nine returns -> first eight pops LIFO, ninth predicts pc+4 with count 0.
REQ-038 SHALL test: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no RAS change; flush then -> out_valid=0 next cycle.
